// File: rtl/seg7_pkg.sv
// Shared seven-segment types and the active-low hex glyph table.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  // Active-low glyphs for 0..F; bit0 = a ... bit6 = g.
  localparam seg7_t HEX_SEG7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  always_comb begin
    seg = HEX_SEG7[hex];
  end

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed common-anode seven-segment scanner; advances one digit per
// rising edge of the divider's tick level, with per-scan input snapshots.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [DIGITS-1:0]     o_an,
  output seg7_t                 o_seg,
  output logic                  o_dp
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [IDX_W-1:0]    idx;
  logic                tick_q;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   dp_q;

  logic                step;
  logic                wrap;
  logic [3:0]          sel_nib;
  logic                sel_blank;
  logic                sel_dp;
  logic [DIGITS-1:0]   an_next;
  seg7_t               seg_dec;

  assign step = i_tick & ~tick_q;
  assign wrap = step && (idx == LAST_IDX);

  // Explicit compare-mux keeps selects in range for non-power-of-two DIGITS.
  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    an_next   = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_nib    = data_q[4*k +: 4];
        sel_blank  = blank_q[k];
        sel_dp     = dp_q[k];
        an_next[k] = 1'b0;
      end
    end
    if (sel_blank) begin
      an_next = '1;
    end
  end

  hex_to_seg7 u_dec (
    .hex (sel_nib),
    .seg (seg_dec)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx     <= '0;
      tick_q  <= 1'b1;
      data_q  <= i_data;
      blank_q <= i_blank;
      dp_q    <= i_dp;
      o_an    <= '1;
      o_seg   <= SEG7_BLANK;
      o_dp    <= 1'b1;
    end else begin
      tick_q <= i_tick;
      if (step) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      // Snapshot only at the start of a new scan so a scan never tears.
      if (wrap) begin
        data_q  <= i_data;
        blank_q <= i_blank;
        dp_q    <= i_dp;
      end
      o_an  <= an_next;
      o_seg <= sel_blank ? SEG7_BLANK : seg_dec;
      o_dp  <= sel_blank | ~sel_dp;
    end
  end

endmodule
